// File: rtl/spi_reg_follower.sv
// rtl/spi_reg_follower.sv - SPI mode-0 responder mapping frames onto a register file
// Optional macro SPI_REG_STATUS_EN: status byte {err_sticky, 3'b000, frame_cnt} shifted out during CMD.
module spi_reg_follower #(
    parameter int DATA_LEN = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 7
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         cs,
    input  logic                         mosi,
    output logic                         miso,
    output logic [NUM_REGS*DATA_LEN-1:0] regs_flat,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic                         busy
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int BW = $clog2(DATA_LEN);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_t;

    state_t               state_q, state_d;
    logic                 sclk_m_q, sclk_s_q, sclk_p_q;
    logic                 cs_m_q, cs_s_q, cs_p_q;
    logic                 mosi_m_q, mosi_s_q;
    logic [1:0]           vld_q;
    logic                 armed_q, armed_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_LEN-1:0]  rx_q, rx_d, tx_q, tx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic                 miso_q, miso_d, wr_pulse_q, wr_pulse_d, frame_err_q, frame_err_d;
    logic [DATA_LEN-1:0]  regs_q [NUM_REGS];
    logic [DATA_LEN-1:0]  regs_d [NUM_REGS];

    logic                 sclk_rise, sclk_fall, cs_fall, cs_rise, byte_done;
    logic [DATA_LEN-1:0]  rx_byte, rd_data, status;
    logic [ADDR_W-1:0]    addr_inc, rd_addr;

`ifdef SPI_REG_STATUS_EN
    logic [3:0]           frame_cnt_q, frame_cnt_d;
    logic                 err_q, err_d;
    assign status = {err_q, {(DATA_LEN-5){1'b0}}, frame_cnt_q};
`else
    assign status = '0;
`endif

    assign sclk_rise = sclk_s_q & ~sclk_p_q;
    assign sclk_fall = ~sclk_s_q & sclk_p_q;
    // A falling cs only starts a frame once cs has genuinely been seen high after reset.
    assign cs_fall   = ~cs_s_q & cs_p_q & armed_q;
    assign cs_rise   = cs_s_q & ~cs_p_q;
    assign byte_done = sclk_rise && (bit_cnt_q == BW'(DATA_LEN-1));
    assign rx_byte   = {rx_q[DATA_LEN-2:0], mosi_s_q};
    assign addr_inc  = (addr_q == ADDR_W'(NUM_REGS-1)) ? '0 : addr_q + 1'b1;
    assign rd_addr   = (state_q == S_CMD) ? rx_byte[ADDR_W-1:0] : addr_inc;
    assign rd_data   = ({1'b0, rd_addr} < (ADDR_W+1)'(NUM_REGS)) ? regs_q[rd_addr[IW-1:0]] : '0;

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | (vld_q[1] & cs_s_q);
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wr_addr_d   = wr_addr_q;
        miso_d      = miso_q;
        wr_pulse_d  = 1'b0;
        frame_err_d = 1'b0;
        regs_d      = regs_q;
`ifdef SPI_REG_STATUS_EN
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
`endif
        if (state_q == S_IDLE) begin
            if (cs_fall) begin
                state_d   = S_CMD;
                bit_cnt_d = '0;
                // First status bit must be on miso before the first sampling edge.
                miso_d    = status[DATA_LEN-1];
                tx_d      = {status[DATA_LEN-2:0], 1'b0};
            end
        end else begin
            if (sclk_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (byte_done) begin
                bit_cnt_d = '0;
                case (state_q)
                    S_CMD: begin
                        addr_d  = rx_byte[ADDR_W-1:0];
                        state_d = rx_byte[DATA_LEN-1] ? S_RD : S_WR;
                        if (rx_byte[DATA_LEN-1]) tx_d = rd_data;
`ifdef SPI_REG_STATUS_EN
                        err_d   = 1'b0;
`endif
                    end
                    S_WR: begin
                        if ({1'b0, addr_q} < (ADDR_W+1)'(NUM_REGS)) begin
                            regs_d[addr_q[IW-1:0]] = rx_byte;
                            wr_pulse_d             = 1'b1;
                            wr_addr_d              = addr_q;
                        end
                        addr_d = addr_inc;
                    end
                    default: begin
                        addr_d = addr_inc;
                        tx_d   = rd_data;
                    end
                endcase
            end
            if (sclk_fall) begin
                miso_d = tx_q[DATA_LEN-1];
                tx_d   = {tx_q[DATA_LEN-2:0], 1'b0};
            end
            // Frame end is applied after any byte completing in the same cycle.
            if (cs_rise) begin
                state_d     = S_IDLE;
                miso_d      = 1'b0;
                frame_err_d = (bit_cnt_d != '0);
`ifdef SPI_REG_STATUS_EN
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (frame_err_d) err_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sclk_m_q    <= 1'b0;
            sclk_s_q    <= 1'b0;
            sclk_p_q    <= 1'b0;
            cs_m_q      <= 1'b1;
            cs_s_q      <= 1'b1;
            cs_p_q      <= 1'b1;
            mosi_m_q    <= 1'b0;
            mosi_s_q    <= 1'b0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            miso_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            frame_err_q <= 1'b0;
            regs_q      <= '{default: '0};
`ifdef SPI_REG_STATUS_EN
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_m_q    <= sclk;
            sclk_s_q    <= sclk_m_q;
            sclk_p_q    <= sclk_s_q;
            cs_m_q      <= cs;
            cs_s_q      <= cs_m_q;
            cs_p_q      <= cs_s_q;
            mosi_m_q    <= mosi;
            mosi_s_q    <= mosi_m_q;
            vld_q       <= {vld_q[0], 1'b1};
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wr_addr_q   <= wr_addr_d;
            miso_q      <= miso_d;
            wr_pulse_q  <= wr_pulse_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
`ifdef SPI_REG_STATUS_EN
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[i*DATA_LEN +: DATA_LEN] = regs_q[i];
    end

    assign miso      = miso_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_reg_follower.sv
// tb/tb_spi_reg_follower.sv - directed and random frames checked against a register-file model
module tb_spi_reg_follower;
    localparam int HALF = 8;

    logic         sys_clk = 1'b0;
    logic         rst_n   = 1'b0;
    logic         sclk    = 1'b0;
    logic         cs      = 1'b1;
    logic         mosi    = 1'b0;
    logic         miso;
    logic [127:0] regs_flat;
    logic         wr_pulse;
    logic [6:0]   wr_addr;
    logic         frame_err;
    logic         busy;

    spi_reg_follower dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         fe_n = 0;
    logic [6:0] wq[$];
    logic [7:0] txb[$];
    logic [7:0] rxb[$];
    logic [7:0] model[16];
    int         cnt_m = 0;
    logic       err_m = 1'b0;

    always @(negedge sys_clk) begin
        if (wr_pulse) wq.push_back(wr_addr);
        if (frame_err) fe_n++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [127:0] pack();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = model[i];
        return r;
    endfunction

    function automatic int next_addr(input int a);
        return (a == 15) ? 0 : (a + 1) % 128;
    endfunction

    task automatic send_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = '0;
        for (int k = 0; k < nb; k++) begin
            mosi = b[7-k];
            tick(HALF);
            r = {r[6:0], miso};
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int last_bits);
        logic [7:0] r;
        rxb.delete();
        cs = 1'b0;
        tick(HALF);
        @(negedge sys_clk);
        chk("busy_in_frame", busy, 1);
        for (int i = 0; i < txb.size(); i++) begin
            send_bits(txb[i], (i == txb.size() - 1) ? last_bits : 8, r);
            rxb.push_back(r);
        end
        tick(HALF);
        cs = 1'b1;
        mosi = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic frame_and_model(input int last_bits);
        logic [7:0] cmd, stat;
        int         a, fe0;
        bit         cmd_full, aborted, full;
        logic [6:0] epq[$];
        cmd = txb[0];
        a = int'(cmd[6:0]);
`ifdef SPI_REG_STATUS_EN
        stat = {err_m, 3'b000, 4'(cnt_m)};
`else
        stat = 8'h00;
`endif
        wq.delete();
        fe0 = fe_n;
        run_frame(last_bits);
        cmd_full = (txb.size() > 1) || (last_bits == 8);
        aborted = (last_bits != 8);
        if (cmd_full) chk("status_byte", rxb[0], stat);
        for (int i = 1; i < txb.size(); i++) begin
            full = (i < txb.size() - 1) || (last_bits == 8);
            if (full) begin
                if (cmd[7]) begin
                    chk("read_byte", rxb[i], (a < 16) ? model[a] : 8'h00);
                end else if (a < 16) begin
                    model[a] = txb[i];
                    epq.push_back(7'(a));
                end
                a = next_addr(a);
            end
        end
        chk("wr_pulse_count", wq.size(), epq.size());
        for (int j = 0; j < epq.size() && j < wq.size(); j++) chk("wr_addr", wq[j], epq[j]);
        chk("frame_err_count", fe_n - fe0, aborted ? 1 : 0);
        chk("regs_flat", regs_flat, pack());
        if (cmd_full) err_m = 1'b0;
        if (aborted) err_m = 1'b1;
        cnt_m = (cnt_m + 1) % 16;
    endtask

    initial begin
        logic [7:0] r;
        int         a, n, fe0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        tick(3);
        @(negedge sys_clk);
        chk("rst_regs", regs_flat, 0);
        chk("rst_miso", miso, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(5);

        txb = '{8'h03, 8'hA5};              frame_and_model(8);
        txb = '{8'h83, 8'h00};              frame_and_model(8);
        txb = '{8'h0E, 8'h11, 8'h22, 8'h33}; frame_and_model(8);
        txb = '{8'h00, 8'h01, 8'h02, 8'h03}; frame_and_model(8);
        txb = '{8'h80, 8'h00, 8'h00, 8'h00}; frame_and_model(8);
        txb = '{8'h20, 8'hFF};              frame_and_model(8);
        txb = '{8'hA0, 8'h00};              frame_and_model(8);
        txb = '{8'h05, 8'hF0};              frame_and_model(4);
        txb = '{8'h05, 8'h3C};              frame_and_model(8);
        txb = '{8'h85, 8'h00};              frame_and_model(8);
        txb = '{8'h8F, 8'h00, 8'h00};       frame_and_model(8);

        for (int it = 0; it < 10; it++) begin
            a = $urandom_range(0, 23);
            n = $urandom_range(1, 4);
            txb = '{{1'($urandom_range(0, 1)), 7'(a)}};
            for (int j = 0; j < n; j++) txb.push_back(8'($urandom_range(0, 255)));
            frame_and_model(8);
        end

        cs = 1'b0;
        tick(HALF);
        send_bits(8'h05, 8, r);
        send_bits(8'h99, 4, r);
        rst_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst_regs", regs_flat, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_miso", miso, 0);
        chk("midrst_wr_pulse", wr_pulse, 0);
        chk("midrst_frame_err", frame_err, 0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        cnt_m = 0;
        err_m = 1'b0;
        sclk = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        wq.delete();
        fe0 = fe_n;
        send_bits(8'h05, 8, r);
        send_bits(8'h77, 8, r);
        tick(HALF);
        @(negedge sys_clk);
        chk("cs_low_after_rst_busy", busy, 0);
        chk("cs_low_after_rst_pulses", wq.size(), 0);
        cs = 1'b1;
        mosi = 1'b0;
        tick(2 * HALF);
        chk("cs_low_after_rst_regs", regs_flat, 0);
        chk("cs_low_after_rst_err", fe_n - fe0, 0);

        txb = '{8'h05, 8'h3C}; frame_and_model(8);
        txb = '{8'h85, 8'h00}; frame_and_model(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
